// File: rtl/mem_port_arbiter.sv
// Shares the single-ported memory between instruction fetch and data (load/store); optional counters under ARB_STATS_EN.
// Latency: registered grant, done combinational with mem_done (min 1 cycle after request seen); one idle bubble between accesses.
// Backpressure: requesters hold until their done pulse (if_stall/dm_stall); a stuck memory times out with rdata 16'hFFFF.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_done,
  output logic [15:0] if_rdata,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        dm_done,
  output logic [15:0] dm_rdata,
  output logic        dm_stall,
  input  logic        halt,
  output logic        halted,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        err,
  output logic [15:0] stat_if_wait,
  output logic [15:0] stat_dm_grant
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] TMO_LIM    = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HALTED} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        owner_dm;
  logic [3:0]  starve_cnt;
  logic [7:0]  wait_cnt;
  logic        grant;
  logic        grant_dm;
  logic        xfer_end;
  logic        timed_out;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state, arbitration decision and completion pulses
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_dm  = 1'b0;
    xfer_end  = 1'b0;
    timed_out = 1'b0;
    if_done   = 1'b0;
    dm_done   = 1'b0;
    if_rdata  = 16'h0;
    dm_rdata  = 16'h0;
    unique case (state)
      S_IDLE: begin
        if (halt) begin
          state_nxt = S_HALTED;
        end else if (if_req || dm_req) begin
          grant     = 1'b1;
          // data has priority unless fetch has been passed over too often
          grant_dm  = dm_req && !(if_req && (starve_cnt == STARVE_LIM));
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (mem_done) begin
          xfer_end  = 1'b1;
          state_nxt = halt ? S_HALTED : S_IDLE;
        end else if ((state == S_WAIT) && (wait_cnt == TMO_LIM)) begin
          xfer_end  = 1'b1;
          timed_out = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_IDLE;
    endcase
    if (xfer_end) begin
      if (owner_dm) begin
        dm_done  = 1'b1;
        dm_rdata = timed_out ? 16'hFFFF : (mem_wr ? 16'h0 : mem_rdata);
      end else begin
        if_done  = 1'b1;
        if_rdata = timed_out ? 16'hFFFF : mem_rdata;
      end
    end
  end

  // Grant capture: owner, memory command registers and the starvation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_dm   <= 1'b0;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= 16'h0;
      mem_wdata  <= 16'h0;
      starve_cnt <= 4'h0;
    end else begin
      mem_en <= grant;
      if (grant) begin
        owner_dm  <= grant_dm;
        mem_addr  <= grant_dm ? dm_addr : if_addr;
        mem_wr    <= grant_dm & dm_wr;
        mem_wdata <= grant_dm ? dm_wdata : 16'h0;
        if (!grant_dm)
          starve_cnt <= 4'h0;
        else if (if_req && (starve_cnt != STARVE_LIM))
          starve_cnt <= starve_cnt + 4'h1;
      end
    end
  end

  // Wait-cycle counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 8'h0;
      err      <= 1'b0;
    end else begin
      if (state == S_ISSUE)
        wait_cnt <= 8'h0;
      else if ((state == S_WAIT) && !mem_done && (wait_cnt != TMO_LIM))
        wait_cnt <= wait_cnt + 8'h1;
      if (timed_out)
        err <= 1'b1;
    end
  end

  assign halted   = (state == S_HALTED);
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

`ifdef ARB_STATS_EN
  logic [15:0] if_wait_cnt;
  logic [15:0] dm_grant_cnt;

  // Free-running wrap-around statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_wait_cnt  <= 16'h0;
      dm_grant_cnt <= 16'h0;
    end else begin
      if (if_stall)
        if_wait_cnt <= if_wait_cnt + 16'h1;
      if (grant && grant_dm)
        dm_grant_cnt <= dm_grant_cnt + 16'h1;
    end
  end

  assign stat_if_wait  = if_wait_cnt;
  assign stat_dm_grant = dm_grant_cnt;
`else
  assign stat_if_wait  = 16'h0;
  assign stat_dm_grant = 16'h0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a behavioural memory and reference model.
// Latency: checks request-to-done timing, grant bubble and timeout age.
// Backpressure: requesters hold until done; memory latency is randomized.
module tb_mem_port_arbiter;
  localparam int STARVE_MAX = 3;
  localparam int TIMEOUT    = 15;

  logic        clk, rst;
  logic        if_req, if_done, if_stall;
  logic [15:0] if_addr, if_rdata;
  logic        dm_req, dm_wr, dm_done, dm_stall;
  logic [15:0] dm_addr, dm_wdata, dm_rdata;
  logic        halt, halted;
  logic        mem_en, mem_wr, mem_done, err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] stat_if_wait, stat_dm_grant;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .halt(halt), .halted(halted),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err),
    .stat_if_wait(stat_if_wait), .stat_dm_grant(stat_dm_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit dm; int cyc; } grant_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_dm_done_cyc = 0;
  logic [15:0] exp_if[$];
  logic [15:0] exp_dm[$];
  grant_t      grant_log[$];
  logic [15:0] ref_mem[int];
  logic [15:0] dev_mem[int];
  bit          if_en = 0, dm_en = 0, if_b2b = 0, dm_b2b = 0;
  bit          tmo_mode = 0, mem_never = 0, late_pulse = 0, stores_ok = 0;
  bit          s_if_done = 0, s_dm_done = 0;
  int          lat_lo = 0, lat_hi = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int lim);
    n_tests++;
    n_fail++;
    $display("FAIL %s: waited %0d cycles, limit %0d", name, act, lim);
  endtask

  function automatic logic [15:0] init_val(input int a);
    return 16'(a * 7) ^ 16'hC3A5;
  endfunction

  function automatic logic [15:0] ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Issue a fetch; the expected instruction comes from the reference memory
  task automatic new_fetch(input logic [15:0] a);
    if_addr = a;
    exp_if.push_back(tmo_mode ? 16'hFFFF : ref_read(int'(a)));
    if_req = 1'b1;
  endtask

  // Issue a load/store; stores update the reference memory at issue (data port is serial)
  task automatic new_data(input bit wr, input logic [15:0] a, input logic [15:0] wd);
    dm_addr  = a;
    dm_wr    = wr;
    dm_wdata = wd;
    if (tmo_mode)  exp_dm.push_back(16'hFFFF);
    else if (wr) begin exp_dm.push_back(16'h0); ref_mem[int'(a)] = wd; end
    else           exp_dm.push_back(ref_read(int'(a)));
    dm_req = 1'b1;
  endtask

  task automatic rand_data();
    bit wr;
    wr = stores_ok && ($urandom_range(0, 1) == 1);
    new_data(wr, 16'($urandom_range(767, 256)), 16'($urandom));
  endtask

  task automatic samp();
    @(negedge clk); #4;
  endtask

  task automatic drv();
    @(posedge clk); #2;
  endtask

  task automatic wait_done(input bit dm, input int max, output int n);
    n = 0;
    do begin samp(); n++; end while (!(dm ? dm_done : if_done) && n < max);
    if (!(dm ? dm_done : if_done)) fail_now(dm ? "dm_done_wait" : "if_done_wait", n, max);
  endtask

  task automatic wait_mem_en(input int max);
    int n;
    n = 0;
    do begin samp(); n++; end while (!mem_en && n < max);
    if (!mem_en) fail_now("mem_en_wait", n, max);
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((if_req || dm_req || exp_if.size() != 0 || exp_dm.size() != 0) && n < max) begin
      samp(); n++;
    end
    if (n >= max) fail_now("drain", n, max);
    samp(); samp();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_wr"}, mem_wr, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_if_done"}, if_done, 0);
    chk({tag, "_dm_done"}, dm_done, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_dm_rdata"}, dm_rdata, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_stalls"}, {if_stall, dm_stall}, 0);
    chk({tag, "_stats"}, {stat_if_wait, stat_dm_grant}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; halt = 1'b0;
    #1 chk_zero("rst_pulse");
    exp_if.delete(); exp_dm.delete();
    @(posedge clk); #2 rst = 1'b0;
  endtask

  // Behavioural memory: accepts mem_en, answers after a random latency
  initial begin : mem_model
    bit          busy;
    int          cnt;
    logic [15:0] a, wd;
    bit          wr;
    busy = 0; cnt = 0; a = 0; wd = 0; wr = 0;
    forever begin
      @(negedge clk);
      mem_done  = 1'b0;
      mem_rdata = 16'h0;
      if (rst) begin
        busy = 0;
      end else begin
        if (late_pulse) begin mem_done = 1'b1; mem_rdata = 16'h1234; late_pulse = 0; end
        if (mem_en && !mem_never) begin
          busy = 1; cnt = $urandom_range(lat_hi, lat_lo);
          a = mem_addr; wr = mem_wr; wd = mem_wdata;
        end
        if (busy) begin
          if (cnt == 0) begin
            busy = 0;
            mem_done = 1'b1;
            if (wr) dev_mem[int'(a)] = wd;
            else    mem_rdata = dev_mem.exists(int'(a)) ? dev_mem[int'(a)] : init_val(int'(a));
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Fetch requester
  initial begin : if_drv
    forever begin
      @(posedge clk); #1;
      if (rst) if_req = 1'b0;
      else if (if_req) begin
        if (s_if_done) begin
          if_req = 1'b0;
          if (if_en && if_b2b) new_fetch(16'($urandom_range(255, 0)));
        end
      end else if (if_en && (if_b2b || $urandom_range(0, 2) == 0))
        new_fetch(16'($urandom_range(255, 0)));
    end
  end

  // Data requester
  initial begin : dm_drv
    forever begin
      @(posedge clk); #1;
      if (rst) dm_req = 1'b0;
      else if (dm_req) begin
        if (s_dm_done) begin
          dm_req = 1'b0;
          if (dm_en && dm_b2b) rand_data();
        end
      end else if (dm_en && (dm_b2b || $urandom_range(0, 2) == 0))
        rand_data();
    end
  end

  // Monitor: pops the scoreboard on each done, checks grants against the arbitration rules
  initial begin : monitor
    bit          g_dm, tmo, err_exp, p_if, p_dm, p_en;
    int          age, starve, m_if_wait, m_dm_grant;
    grant_t      g;
    logic [15:0] e;
    err_exp = 0; p_if = 0; p_dm = 0; p_en = 0;
    age = 0; starve = 0; m_if_wait = 0; m_dm_grant = 0;
    forever begin
      @(negedge clk); #3;
      cyc++;
      if (rst) begin
        err_exp = 0; p_if = 0; p_dm = 0; p_en = 0;
        age = 0; starve = 0; m_if_wait = 0; m_dm_grant = 0;
        s_if_done = 0; s_dm_done = 0;
      end else begin
        if (mem_en) begin
          chk("mem_en_one_cycle", p_en, 0);
          g_dm = (mem_addr >= 16'h0100);
          g.dm = g_dm; g.cyc = cyc;
          grant_log.push_back(g);
          if (g_dm) begin
            chk("dm_grant_req", p_dm, 1);
            chk("dm_grant_addr", mem_addr, dm_addr);
            chk("dm_grant_wr", mem_wr, dm_wr);
            chk("dm_grant_wdata", mem_wdata, dm_wdata);
            chk("dm_grant_starved_if", p_if && (starve == STARVE_MAX), 0);
            if (p_if && starve < STARVE_MAX) starve++;
            m_dm_grant++;
          end else begin
            chk("if_grant_req", p_if, 1);
            chk("if_grant_addr", mem_addr, if_addr);
            chk("if_grant_rd", {mem_wr, mem_wdata}, 0);
            chk("if_grant_prio", p_dm && (starve != STARVE_MAX), 0);
            starve = 0;
          end
          age = 0;
        end else begin
          age++;
        end
        tmo = 0;
        if (if_done || dm_done) begin
          chk("single_done", if_done && dm_done, 0);
          tmo = !mem_done;
          chk("timeout_kind", tmo, tmo_mode);
          if (tmo) chk("timeout_age", age, TIMEOUT + 1);
        end
        if (if_done) begin
          chk("if_done_pending", exp_if.size(), 1);
          if (exp_if.size() != 0) begin e = exp_if.pop_front(); chk("if_rdata", if_rdata, e); end
        end
        if (dm_done) begin
          last_dm_done_cyc = cyc;
          chk("dm_done_pending", exp_dm.size(), 1);
          if (exp_dm.size() != 0) begin e = exp_dm.pop_front(); chk("dm_rdata", dm_rdata, e); end
        end
        chk("err", err, err_exp);
        if (tmo) err_exp = 1;
        chk("if_stall", if_stall, if_req & ~if_done);
        chk("dm_stall", dm_stall, dm_req & ~dm_done);
`ifdef ARB_STATS_EN
        chk("stat_if_wait", stat_if_wait, 16'(m_if_wait));
        chk("stat_dm_grant", stat_dm_grant, 16'(m_dm_grant));
`else
        chk("stat_if_wait_off", stat_if_wait, 0);
        chk("stat_dm_grant_off", stat_dm_grant, 0);
`endif
        if (if_req && !if_done) m_if_wait++;
        p_if = if_req; p_dm = dm_req; p_en = mem_en;
        s_if_done = if_done; s_dm_done = dm_done;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    rst = 1'b1; halt = 1'b0;
    if_req = 1'b0; if_addr = 16'h0;
    dm_req = 1'b0; dm_wr = 1'b0; dm_addr = 16'h0; dm_wdata = 16'h0;
    mem_done = 1'b0; mem_rdata = 16'h0;
    #1 chk_zero("reset");
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    samp();

    // zero-wait fetch: done one cycle after the request is seen
    dev_mem[16'h0010] = 16'h4321; ref_mem[16'h0010] = 16'h4321;
    lat_lo = 0; lat_hi = 0;
    drv(); new_fetch(16'h0010);
    wait_done(0, 20, n);
    chk("zw_latency", n, 2);
    chk("zw_mem_en", mem_en, 1);
    chk("zw_mem_addr", mem_addr, 16'h0010);
    chk("zw_if_rdata", if_rdata, 16'h4321);
    drain(50);

    // simultaneous store and fetch: data first, fetch after one bubble
    lat_lo = 1; lat_hi = 1;
    grant_log.delete();
    drv(); new_data(1, 16'h0200, 16'hBEEF); new_fetch(16'h0044);
    wait_mem_en(10);
    chk("both_first_wr", mem_wr, 1);
    chk("both_first_wdata", mem_wdata, 16'hBEEF);
    n = 0;
    while (grant_log.size() < 2 && n < 20) begin samp(); n++; end
    if (grant_log.size() < 2) fail_now("both_grants", n, 20);
    else begin
      chk("both_order", {grant_log[0].dm, grant_log[1].dm}, 2'b10);
      chk("both_bubble", grant_log[1].cyc - last_dm_done_cyc, 2);
    end
    drain(50);

    // starvation guard: both ports always requesting
    grant_log.delete();
    lat_lo = 0; lat_hi = 2; stores_ok = 1;
    if_b2b = 1; dm_b2b = 1; if_en = 1; dm_en = 1;
    n = 0;
    while (grant_log.size() < 12 && n < 400) begin samp(); n++; end
    if_en = 0; dm_en = 0; if_b2b = 0; dm_b2b = 0;
    if (grant_log.size() < 12) fail_now("starve_grants", n, 400);
    else for (int i = 0; i < 12; i++) chk($sformatf("starve_seq%0d", i), grant_log[i].dm, (i % 4) != 3);
    drain(200);

    // random traffic with random memory latency
    lat_lo = 0; lat_hi = 3;
    if_en = 1; dm_en = 1;
    repeat (600) samp();
    if_en = 0; dm_en = 0;
    drain(200);
    chk("rand_if_queue_empty", exp_if.size(), 0);
    chk("rand_dm_queue_empty", exp_dm.size(), 0);

    // memory never answers: timeout, sticky err, late mem_done ignored
    tmo_mode = 1; mem_never = 1;
    drv(); new_data(0, 16'h0123, 16'h0);
    wait_done(1, 60, n);
    chk("tmo_rdata", dm_rdata, 16'hFFFF);
    samp(); samp();
    chk("tmo_err_sticky", err, 1);
    late_pulse = 1;
    repeat (3) begin samp(); chk("late_done", {if_done, dm_done}, 0); end
    tmo_mode = 0; mem_never = 0;
    drain(50);

    // halt mid-WAIT of a load
    lat_lo = 3; lat_hi = 3;
    drv(); new_data(0, 16'h0180, 16'h0);
    wait_mem_en(10);
    samp();
    halt = 1'b1;
    wait_done(1, 20, n);
    samp();
    chk("halt_halted", halted, 1);
    if_addr = 16'h0020; if_req = 1'b1;
    n = 0;
    repeat (10) begin samp(); n += int'(mem_en) + int'(if_done); end
    chk("halt_no_grant", n, 0);
    halt = 1'b0;
    samp(); samp();
    chk("halt_stays", halted, 1);
    if_req = 1'b0;
    do_reset();
    samp();
    chk("halt_cleared", halted, 0);

    // asynchronous reset during WAIT, then a normal request
    lat_lo = 8; lat_hi = 8;
    drv(); new_data(0, 16'h0150, 16'h0);
    wait_mem_en(10);
    samp(); samp();
    @(negedge clk); #1;
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0;
    #1 chk_zero("rst_in_wait");
    exp_if.delete(); exp_dm.delete();
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    lat_lo = 0; lat_hi = 0;
    drv(); new_fetch(16'h0077);
    wait_done(0, 20, n);
    chk("post_rst_latency", n, 2);
    drain(50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
